// File: rtl/snd_cmd_queue_if.sv
// Command-side and play-side signals of the sound-command queue.
// master = CPU/sound-board environment, slave = the queue itself.
interface snd_cmd_queue_if;
    logic       cmd_wr;
    logic [7:0] cmd_dt;
    logic [7:0] sndno;
    logic       sndstart;
    logic       cmd_full;
    logic       cmd_ovf;
    logic       busy;

    modport master (output cmd_wr, cmd_dt,
                    input  sndno, sndstart, cmd_full, cmd_ovf, busy);
    modport slave  (input  cmd_wr, cmd_dt,
                    output sndno, sndstart, cmd_full, cmd_ovf, busy);
endinterface

// File: rtl/snd_cmd_queue.sv
// Buffers CPU sound-command bytes and replays them as spaced sndno/sndstart requests.
// Build option: SNDCMD_DROPOLD_EN makes a write into a full FIFO evict the oldest entry.
module snd_cmd_queue #(
    parameter int DEPTH   = 4,
    parameter int HOLD    = 8,
    parameter int SPACING = 8000
) (
    input logic            clk8M,
    input logic            reset,
    snd_cmd_queue_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(SPACING);

    typedef enum logic [1:0] {IDLE, ASSERT, SPACE} state_t;

    state_t         state;
    logic [TW-1:0]  timer;
    logic [7:0]     mem [DEPTH];
    logic [AW-1:0]  rd_ptr, wr_ptr;
    logic [CW-1:0]  count;
    logic [7:0]     sndno_q;
    logic           sndstart_q;
    logic           ovf_q;

    logic full, empty, pop, wr_full, push, drop, rd_adv;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign pop     = (state == IDLE) && !empty;
    // A pop in the same cycle frees a slot, so only a write with no pop counts as overflow.
    assign wr_full = bus.cmd_wr && full && !pop;

`ifdef SNDCMD_DROPOLD_EN
    assign push = bus.cmd_wr;
    assign drop = wr_full;
`else
    assign push = bus.cmd_wr && !wr_full;
    assign drop = 1'b0;
`endif

    assign rd_adv = pop || drop;

    // Storage needs no reset: emptiness is tracked by count.
    always_ff @(posedge clk8M) begin
        if (push) mem[wr_ptr] <= bus.cmd_dt;
    end

    always_ff @(posedge clk8M) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            ovf_q  <= 1'b0;
        end else begin
            if (push)   wr_ptr <= wr_ptr + AW'(1);
            if (rd_adv) rd_ptr <= rd_ptr + AW'(1);
            if (push && !rd_adv)      count <= count + CW'(1);
            else if (rd_adv && !push) count <= count - CW'(1);
            if (wr_full) ovf_q <= 1'b1;
        end
    end

    always_ff @(posedge clk8M) begin
        if (reset) begin
            state      <= IDLE;
            timer      <= '0;
            sndno_q    <= 8'h00;
            sndstart_q <= 1'b0;
        end else begin
            case (state)
                IDLE: if (!empty) begin
                    sndno_q    <= mem[rd_ptr];
                    sndstart_q <= 1'b1;
                    timer      <= '0;
                    state      <= ASSERT;
                end
                ASSERT: begin
                    timer <= timer + TW'(1);
                    if (timer == TW'(HOLD - 1)) begin
                        sndstart_q <= 1'b0;
                        state      <= SPACE;
                    end
                end
                SPACE: begin
                    // Hold the timer on exit so it cannot wrap when SPACING is a power of two.
                    if (timer == TW'(SPACING - 1)) state <= IDLE;
                    else                           timer <= timer + TW'(1);
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.sndno    = sndno_q;
    assign bus.sndstart = sndstart_q;
    assign bus.cmd_full = full;
    assign bus.cmd_ovf  = ovf_q;
    assign bus.busy     = (state != IDLE) || !empty;
endmodule

// File: tb/tb_snd_cmd_queue.sv
// Directed bench: default-parameter instance for timing, short-SPACING instance for ordering.
module tb_snd_cmd_queue;
    logic clk8M = 1'b0;
    logic reset = 1'b1;
    int   cyc   = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk8M = ~clk8M;
    always @(posedge clk8M) cyc <= cyc + 1;

    snd_cmd_queue_if bi();
    snd_cmd_queue_if si();

    snd_cmd_queue dut_big (.clk8M(clk8M), .reset(reset), .bus(bi));
    snd_cmd_queue #(.DEPTH(4), .HOLD(4), .SPACING(20))
        dut_small (.clk8M(clk8M), .reset(reset), .bus(si));

    task automatic step();
        @(posedge clk8M);
        #1;
    endtask

    task automatic clr();
        bi.cmd_wr = 1'b0; bi.cmd_dt = 8'h00;
        si.cmd_wr = 1'b0; si.cmd_dt = 8'h00;
    endtask

    task automatic do_reset();
        clr();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    // Write sampled at the next edge; strobe stays up until clr().
    task automatic wr(input bit sm, input logic [7:0] d);
        if (sm) begin si.cmd_wr = 1'b1; si.cmd_dt = d; end
        else    begin bi.cmd_wr = 1'b1; bi.cmd_dt = d; end
        step();
    endtask

    task automatic wait_rise(input bit sm, input int limit, output int at, output bit ok);
        logic prev, cur;
        prev = sm ? si.sndstart : bi.sndstart;
        ok = 1'b0;
        at = 0;
        for (int i = 0; i < limit; i++) begin
            step();
            cur = sm ? si.sndstart : bi.sndstart;
            if (cur && !prev) begin ok = 1'b1; at = cyc; break; end
            prev = cur;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        clr();
        step();
        step();
        checks++; if (bi.sndno !== 8'h00) begin errors++; $display("FAIL reset_sndno got %h exp 00", bi.sndno); end
        checks++; if (bi.sndstart !== 1'b0) begin errors++; $display("FAIL reset_sndstart got %b exp 0", bi.sndstart); end
        checks++; if (bi.cmd_full !== 1'b0) begin errors++; $display("FAIL reset_full got %b exp 0", bi.cmd_full); end
        checks++; if (bi.cmd_ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b exp 0", bi.cmd_ovf); end
        checks++; if (bi.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", bi.busy); end
        reset = 1'b0;
    endtask

    task automatic test_single();
        do_reset();
        wr(0, 8'h12);
        clr();
        checks++; if (bi.busy !== 1'b1) begin errors++; $display("FAIL single_busy_k got %b exp 1", bi.busy); end
        checks++; if (bi.sndstart !== 1'b0) begin errors++; $display("FAIL single_start_k got %b exp 0", bi.sndstart); end
        step();
        checks++; if (bi.sndstart !== 1'b1) begin errors++; $display("FAIL single_start_k1 got %b exp 1", bi.sndstart); end
        checks++; if (bi.sndno !== 8'h12) begin errors++; $display("FAIL single_sndno got %h exp 12", bi.sndno); end
        repeat (7) step();
        checks++; if (bi.sndstart !== 1'b1) begin errors++; $display("FAIL single_hold_last got %b exp 1", bi.sndstart); end
        step();
        checks++; if (bi.sndstart !== 1'b0) begin errors++; $display("FAIL single_hold_end got %b exp 0", bi.sndstart); end
        repeat (7991) step();
        checks++; if (bi.busy !== 1'b1) begin errors++; $display("FAIL single_busy_8000 got %b exp 1", bi.busy); end
        step();
        checks++; if (bi.busy !== 1'b0) begin errors++; $display("FAIL single_busy_8001 got %b exp 0", bi.busy); end
        checks++; if (bi.sndno !== 8'h12) begin errors++; $display("FAIL single_sndno_held got %h exp 12", bi.sndno); end
    endtask

    task automatic test_burst();
        int t0, t1;
        bit ok;
        logic [7:0] exp_b [2];
        exp_b[0] = 8'h02; exp_b[1] = 8'h03;
        do_reset();
        wr(0, 8'h01);
        wr(0, 8'h02);
        checks++; if (bi.sndstart !== 1'b1 || bi.sndno !== 8'h01) begin errors++; $display("FAIL burst_first got %b/%h exp 1/01", bi.sndstart, bi.sndno); end
        t0 = cyc;
        wr(0, 8'h03);
        clr();
        for (int i = 0; i < 2; i++) begin
            wait_rise(0, 9000, t1, ok);
            checks++; if (!ok) begin errors++; $display("FAIL burst_timeout got none exp rise %0d", i); end
            checks++; if (t1 - t0 !== 8001) begin errors++; $display("FAIL burst_interval got %0d exp 8001", t1 - t0); end
            checks++; if (bi.sndno !== exp_b[i]) begin errors++; $display("FAIL burst_sndno got %h exp %h", bi.sndno, exp_b[i]); end
            t0 = t1;
        end
        checks++; if (bi.cmd_ovf !== 1'b0) begin errors++; $display("FAIL burst_ovf got %b exp 0", bi.cmd_ovf); end
    endtask

    task automatic test_overflow();
        int t0, t1, n;
        bit ok;
        logic [7:0] exp_o [4];
`ifdef SNDCMD_DROPOLD_EN
        exp_o[0] = 8'hA2; exp_o[1] = 8'hA3; exp_o[2] = 8'hA4; exp_o[3] = 8'hA5;
`else
        exp_o[0] = 8'hA1; exp_o[1] = 8'hA2; exp_o[2] = 8'hA3; exp_o[3] = 8'hA4;
`endif
        do_reset();
        wr(1, 8'hA0);
        wr(1, 8'hA1);
        checks++; if (si.sndstart !== 1'b1 || si.sndno !== 8'hA0) begin errors++; $display("FAIL ovf_first got %b/%h exp 1/a0", si.sndstart, si.sndno); end
        t0 = cyc;
        wr(1, 8'hA2);
        wr(1, 8'hA3);
        wr(1, 8'hA4);
        checks++; if (si.cmd_full !== 1'b1 || si.cmd_ovf !== 1'b0) begin errors++; $display("FAIL ovf_fill got full=%b ovf=%b exp 1/0", si.cmd_full, si.cmd_ovf); end
        wr(1, 8'hA5);
        clr();
        checks++; if (si.cmd_ovf !== 1'b1) begin errors++; $display("FAIL ovf_set got %b exp 1", si.cmd_ovf); end
        checks++; if (si.cmd_full !== 1'b1) begin errors++; $display("FAIL ovf_full got %b exp 1", si.cmd_full); end
        for (int i = 0; i < 4; i++) begin
            wait_rise(1, 100, t1, ok);
            checks++; if (!ok) begin errors++; $display("FAIL ovf_timeout got none exp rise %0d", i); end
            checks++; if (si.sndno !== exp_o[i]) begin errors++; $display("FAIL ovf_order got %h exp %h", si.sndno, exp_o[i]); end
            checks++; if (t1 - t0 !== 21) begin errors++; $display("FAIL ovf_interval got %0d exp 21", t1 - t0); end
            t0 = t1;
        end
        n = 0;
        while (si.busy && n < 100) begin step(); n++; end
        checks++; if (si.busy !== 1'b0) begin errors++; $display("FAIL ovf_drain got busy=%b exp 0", si.busy); end
        checks++; if (si.cmd_ovf !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %b exp 1", si.cmd_ovf); end
        do_reset();
        checks++; if (si.cmd_ovf !== 1'b0) begin errors++; $display("FAIL ovf_clear got %b exp 0", si.cmd_ovf); end
    endtask

    task automatic test_push_pop_full();
        int tp, t0, t1;
        bit ok;
        logic [7:0] exp_p [4];
        exp_p[0] = 8'hB2; exp_p[1] = 8'hB3; exp_p[2] = 8'hB4; exp_p[3] = 8'h55;
        do_reset();
        wr(1, 8'hB0);
        wr(1, 8'hB1);
        tp = cyc;
        wr(1, 8'hB2);
        wr(1, 8'hB3);
        wr(1, 8'hB4);
        clr();
        while (cyc < tp + 20) step();
        checks++; if (si.sndstart !== 1'b0 || si.cmd_full !== 1'b1) begin errors++; $display("FAIL ppf_pre got start=%b full=%b exp 0/1", si.sndstart, si.cmd_full); end
        wr(1, 8'h55);
        clr();
        checks++; if (si.sndstart !== 1'b1 || si.sndno !== 8'hB1) begin errors++; $display("FAIL ppf_pop got %b/%h exp 1/b1", si.sndstart, si.sndno); end
        checks++; if (si.cmd_full !== 1'b1) begin errors++; $display("FAIL ppf_full got %b exp 1", si.cmd_full); end
        checks++; if (si.cmd_ovf !== 1'b0) begin errors++; $display("FAIL ppf_ovf got %b exp 0", si.cmd_ovf); end
        t0 = cyc;
        for (int i = 0; i < 4; i++) begin
            wait_rise(1, 100, t1, ok);
            checks++; if (!ok) begin errors++; $display("FAIL ppf_timeout got none exp rise %0d", i); end
            checks++; if (si.sndno !== exp_p[i]) begin errors++; $display("FAIL ppf_order got %h exp %h", si.sndno, exp_p[i]); end
            t0 = t1;
        end
        checks++; if (si.cmd_ovf !== 1'b0) begin errors++; $display("FAIL ppf_ovf_end got %b exp 0", si.cmd_ovf); end
    endtask

    task automatic test_reset_mid();
        int active;
        do_reset();
        wr(0, 8'hC1);
        wr(0, 8'hC2);
        wr(0, 8'hC3);
        clr();
        step();
        checks++; if (bi.sndstart !== 1'b1 || bi.sndno !== 8'hC1) begin errors++; $display("FAIL rmid_pre got %b/%h exp 1/c1", bi.sndstart, bi.sndno); end
        reset = 1'b1;
        step();
        reset = 1'b0;
        checks++; if (bi.sndstart !== 1'b0) begin errors++; $display("FAIL rmid_start got %b exp 0", bi.sndstart); end
        checks++; if (bi.sndno !== 8'h00) begin errors++; $display("FAIL rmid_sndno got %h exp 00", bi.sndno); end
        checks++; if (bi.busy !== 1'b0) begin errors++; $display("FAIL rmid_busy got %b exp 0", bi.busy); end
        checks++; if (bi.cmd_full !== 1'b0) begin errors++; $display("FAIL rmid_full got %b exp 0", bi.cmd_full); end
        active = 0;
        for (int i = 0; i < 20000; i++) begin
            step();
            if (bi.sndstart || bi.busy) active++;
        end
        checks++; if (active !== 0) begin errors++; $display("FAIL rmid_replay got %0d active cycles exp 0", active); end
    endtask

    task automatic test_spacing_guard();
        int tp, t1;
        bit ok;
        do_reset();
        wr(0, 8'h06);
        clr();
        tp = cyc + 1;
        while (cyc < tp + 7990) step();
        wr(0, 8'h07);
        clr();
        checks++; if (bi.sndno !== 8'h06) begin errors++; $display("FAIL space_hold got %h exp 06", bi.sndno); end
        wait_rise(0, 100, t1, ok);
        checks++; if (!ok) begin errors++; $display("FAIL space_timeout got none exp rise"); end
        checks++; if (t1 - tp !== 8001) begin errors++; $display("FAIL space_interval got %0d exp 8001", t1 - tp); end
        checks++; if (bi.sndno !== 8'h07) begin errors++; $display("FAIL space_sndno got %h exp 07", bi.sndno); end
    endtask

    initial begin
        clr();
        test_reset();
        test_single();
        test_burst();
        test_overflow();
        test_push_pop_full();
        test_reset_mid();
        test_spacing_guard();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
